// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: extends a raw immediate field according to a 2-bit mode and
// queues the extended result in a small in-order buffer with valid/ready
// handshakes on both sides. Extension happens once, at push time, so the
// buffer stores finished OUT_W-bit results.
//
// Mode | result
// 00   | zero-extend
// 01   | sign-extend from in_imm[IN_W-1]
// 10   | in_imm placed in the high bits, low bits zero
// 11   | sign-extend, then shift left by 2 (upper bits drop off)

module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_W-1:0]            in_imm,
   input  logic [1:0]                 in_mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_imm,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PAD_W = OUT_W - IN_W;

   // DEPTH is a power of two, so pointers wrap naturally from DEPTH-1 to 0.
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [OUT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OUT_W-1:0] sext_val;
   logic [OUT_W-1:0] ext_val;
   logic             push;
   logic             pop;

   // Handshake status comes purely from occupancy; out_ready never reaches in_ready.
   assign in_ready  = (count < CNT_FULL);
   assign out_valid = (count != '0);
   assign out_imm   = out_valid ? mem[rd_ptr] : '0;

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   // Extension of the incoming immediate, selected by mode.
   always_comb begin
      sext_val = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
      ext_val  = '0;
      case (in_mode)
         2'b00:   ext_val = {{PAD_W{1'b0}}, in_imm};
         2'b01:   ext_val = sext_val;
         2'b10:   ext_val = {in_imm, {PAD_W{1'b0}}};
         default: ext_val = {sext_val[OUT_W-3:0], 2'b00};
      endcase
   end

   // Result storage; contents are don't-care until pointed at by a valid count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= ext_val;
      end
   end

   // Pointer and occupancy bookkeeping; flush discards everything, including same-cycle traffic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: directed cases with hand-computed results, then
// randomized traffic, all checked every cycle against a queue-based model.

module tb_imm_ext_pipe;

   localparam int IN_W  = 16;
   localparam int OUT_W = 32;
   localparam int DEPTH = 2;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   in_imm;
   logic [1:0]        in_mode;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_imm;
   logic [CNT_W-1:0]  count;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   logic [OUT_W-1:0] q [$];

   imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Extension from the arithmetic meaning of each mode.
   function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] imm, input logic [1:0] mode);
      longint u, s, r;
      u = longint'(imm);
      s = longint'($signed(imm));
      case (mode)
         2'd0:    r = u;
         2'd1:    r = s;
         2'd2:    r = u * (longint'(1) << (OUT_W - IN_W));
         default: r = s * 4;
      endcase
      return r[OUT_W-1:0];
   endfunction

   // Reference model: an ordered queue of finished results.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else begin
         automatic bit do_push = in_valid && (q.size() < DEPTH);
         automatic bit do_pop  = out_ready && (q.size() > 0);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(ref_ext(in_imm, in_mode));
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("count", 64'(count), 64'(q.size()));
         chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("out_imm", 64'(out_imm), (q.size() != 0) ? 64'(q[0]) : 64'd0);
      end
   end

   task automatic cycle(input logic v, input logic [IN_W-1:0] imm, input logic [1:0] mode,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_imm    = imm;
      in_mode   = mode;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [1:0]       tbl_mode [3];
   logic [OUT_W-1:0] tbl_exp  [3];

   initial begin
      in_valid = 0; in_imm = '0; in_mode = '0; out_ready = 0; flush = 0;
      tbl_mode[0] = 2'b00; tbl_exp[0] = 32'h0000_8001;
      tbl_mode[1] = 2'b10; tbl_exp[1] = 32'h8001_0000;
      tbl_mode[2] = 2'b11; tbl_exp[2] = 32'hFFFE_0004;

      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_imm", 64'(out_imm), 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // sign-extend push into empty buffer
      cycle(1, 16'h8001, 2'b01, 0, 0);
      chk("m01_valid", 64'(out_valid), 64'd1);
      chk("m01_imm", 64'(out_imm), 64'h0000_0000_FFFF_8001);
      chk("m01_count", 64'(count), 64'd1);
      cycle(0, '0, 2'b00, 1, 0);

      // remaining modes
      for (int i = 0; i < 3; i++) begin
         cycle(1, 16'h8001, tbl_mode[i], 0, 0);
         chk("mode_imm", 64'(out_imm), 64'(tbl_exp[i]));
         cycle(0, '0, 2'b00, 1, 0);
      end

      // fill, rejected push while full, drain in order
      cycle(1, 16'h0001, 2'b00, 0, 0);
      cycle(1, 16'h0002, 2'b00, 0, 0);
      chk("full_count", 64'(count), 64'd2);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_head", 64'(out_imm), 64'h1);
      cycle(1, 16'h0009, 2'b00, 1, 0);
      chk("after_reject_count", 64'(count), 64'd1);
      chk("after_reject_head", 64'(out_imm), 64'h2);
      cycle(0, '0, 2'b00, 1, 0);
      chk("drained_valid", 64'(out_valid), 64'd0);

      // simultaneous push/pop at count 1, across pointer wrap
      cycle(1, 16'h0005, 2'b00, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(1, 16'h0003, 2'b00, 1, 0);
         chk("pp_count", 64'(count), 64'd1);
         chk("pp_imm", 64'(out_imm), 64'h3);
      end
      cycle(0, '0, 2'b00, 1, 0);

      // flush with concurrent push
      cycle(1, 16'h0011, 2'b00, 0, 0);
      cycle(1, 16'h0012, 2'b00, 0, 0);
      cycle(1, 16'h0013, 2'b00, 1, 1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_imm", 64'(out_imm), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);

      // asynchronous reset between edges with two entries buffered
      cycle(1, 16'h0021, 2'b00, 0, 0);
      cycle(1, 16'h0022, 2'b00, 0, 0);
      in_valid = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 64'(out_valid), 64'd0);
      chk("async_count", 64'(count), 64'd0);
      chk("async_imm", 64'(out_imm), 64'd0);
      #1 rst_n = 1'b1;
      cycle(1, 16'h7FFF, 2'b01, 0, 0);
      chk("post_rst_imm", 64'(out_imm), 64'h7FFF);
      cycle(0, '0, 2'b00, 1, 0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      end
      cycle(0, '0, 2'b00, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
